// File: rtl/strobe_cmp_reg.sv
// Strobed pin compare against double-buffered EXP/MASK; the cycle result is registered one clock after the last tick.
// The saturating FAIL_COUNT is built only when CMP_FAIL_COUNT_EN is defined, otherwise it is tied to 0.
module strobe_cmp_reg #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en_cmp_logic,
  input  logic             i_load,
  input  logic             i_transfer,
  input  logic             i_exp,
  input  logic             i_mask,
  input  logic [1:0]       i_cmp_mode,
  input  logic [6:0]       i_strobe_edge_1,
  input  logic [6:0]       i_strobe_edge_2,
  input  logic [6:0]       i_window_end_1,
  input  logic [6:0]       i_window_end_2,
  input  logic [7:0]       i_cycle_length_1,
  input  logic [7:0]       i_cycle_length_2,
  input  logic             i_test_cycle,
  input  logic             i_clr_fail,
  input  logic             i_pin_in,
  output logic             o_sample,
  output logic             o_cycle_done,
  output logic             o_cycle_fail,
  output logic             o_fail,
  output logic [CNT_W-1:0] o_fail_count
);
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_WIN, S_POST} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_buf_exp, r_buf_mask, r_act_exp, r_act_mask, r_wrk_exp, r_wrk_mask;
  logic [7:0]             r_cnt, r_len;
  logic [6:0]             r_strobe, r_wend;
  logic [1:0]             r_mode;
  logic                   r_acc;

  logic       w_run, w_tick0, w_last_tick, w_at_strobe, w_check, w_miss, w_pin, w_acc_nxt;
  logic       w_exp, w_mask;
  logic [7:0] w_len, w_last, w_strobe, w_wend, w_wend_clip;
  logic [1:0] w_mode;

  assign w_pin   = r_sync[SYNC_STAGES-1];
  assign w_run   = i_en_cmp_logic && (r_state != S_IDLE);
  assign w_tick0 = w_run && (r_cnt == 8'd0);

  // Tick 0 is timed by the settings it latches, so read them live on that clock.
  assign w_len    = w_tick0 ? (i_test_cycle ? i_cycle_length_2 : i_cycle_length_1) : r_len;
  assign w_strobe = {1'b0, (w_tick0 ? (i_test_cycle ? i_strobe_edge_2 : i_strobe_edge_1) : r_strobe)};
  assign w_wend   = {1'b0, (w_tick0 ? (i_test_cycle ? i_window_end_2 : i_window_end_1) : r_wend)};
  assign w_mode   = w_tick0 ? i_cmp_mode : r_mode;
  assign w_exp    = w_tick0 ? r_act_exp : r_wrk_exp;
  assign w_mask   = w_tick0 ? r_act_mask : r_wrk_mask;

  assign w_last      = (w_len <= 8'd1) ? 8'd0 : w_len - 8'd1;
  assign w_wend_clip = (w_wend > w_last) ? w_last : w_wend;
  assign w_last_tick = w_run && (r_cnt == w_last);
  assign w_at_strobe = w_run && (r_state == S_PRE) && (r_cnt == w_strobe);
  assign w_check     = w_at_strobe || (w_run && (r_state == S_WIN));
  assign w_miss      = (w_pin != w_exp) && !w_mask && (w_mode != 2'b10);
  assign w_acc_nxt   = r_acc || (w_check && w_miss);

  always_comb begin
    w_state_nxt = r_state;
    if (!i_en_cmp_logic) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_PRE;
        S_PRE: begin
          if (w_at_strobe)
            w_state_nxt = ((w_mode == 2'b01) && (w_wend_clip > r_cnt)) ? S_WIN : S_POST;
        end
        S_WIN: begin
          if (r_cnt >= w_wend_clip)
            w_state_nxt = S_POST;
        end
        S_POST:  w_state_nxt = S_POST;
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_last_tick)
        w_state_nxt = S_PRE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_sync       <= '0;
      r_buf_exp    <= 1'b0;
      r_buf_mask   <= 1'b0;
      r_act_exp    <= 1'b0;
      r_act_mask   <= 1'b0;
      r_wrk_exp    <= 1'b0;
      r_wrk_mask   <= 1'b0;
      r_cnt        <= 8'd0;
      r_len        <= 8'd0;
      r_strobe     <= 7'd0;
      r_wend       <= 7'd0;
      r_mode       <= 2'b00;
      r_acc        <= 1'b0;
      o_sample     <= 1'b0;
      o_cycle_done <= 1'b0;
      o_cycle_fail <= 1'b0;
      o_fail       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin_in};

      if (i_load) begin
        r_buf_exp  <= i_exp;
        r_buf_mask <= i_mask;
      end else if (i_transfer) begin
        r_act_exp  <= r_buf_exp;
        r_act_mask <= r_buf_mask;
      end

      if (w_tick0) begin
        r_len      <= w_len;
        r_strobe   <= w_strobe[6:0];
        r_wend     <= w_wend[6:0];
        r_mode     <= w_mode;
        r_wrk_exp  <= r_act_exp;
        r_wrk_mask <= r_act_mask;
      end

      if (!w_run || w_last_tick)
        r_cnt <= 8'd0;
      else
        r_cnt <= r_cnt + 8'd1;

      if (w_at_strobe)
        o_sample <= w_pin;
      o_cycle_done <= w_last_tick;
      if (w_last_tick)
        o_cycle_fail <= w_acc_nxt;
      r_acc  <= (w_last_tick || !w_run) ? 1'b0 : w_acc_nxt;
      o_fail <= (o_fail && !i_clr_fail) || (w_last_tick && w_acc_nxt);
    end
  end

`ifdef CMP_FAIL_COUNT_EN
  logic [CNT_W-1:0] r_fail_count;
  logic             w_cnt_inc;

  assign w_cnt_inc = w_last_tick && w_acc_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_fail_count <= '0;
    else if (i_clr_fail)
      r_fail_count <= {{(CNT_W-1){1'b0}}, w_cnt_inc};
    else if (w_cnt_inc && (r_fail_count != {CNT_W{1'b1}}))
      r_fail_count <= r_fail_count + 1'b1;
  end

  assign o_fail_count = r_fail_count;
`else
  assign o_fail_count = '0;
`endif
endmodule

// File: tb/tb_strobe_cmp_reg.sv
// Bench for strobe_cmp_reg: vector table, hand sequences and a randomized run against a cycle-level model.
module tb_strobe_cmp_reg;
  localparam int S  = 2;
  localparam int CW = 4;
`ifdef CMP_FAIL_COUNT_EN
  localparam int XSAT = 15;
  localparam int XONE = 1;
`else
  localparam int XSAT = 0;
  localparam int XONE = 0;
`endif

  logic clk = 1'b0;
  logic rst, en, load, transfer, exp_v, mask_v, test_cyc, clr, pin;
  logic [1:0] mode;
  logic [6:0] stb1, stb2, wend1, wend2;
  logic [7:0] len1, len2;
  logic sample, done, cfail, fail;
  logic [CW-1:0] fcnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  strobe_cmp_reg #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en_cmp_logic(en), .i_load(load), .i_transfer(transfer),
    .i_exp(exp_v), .i_mask(mask_v), .i_cmp_mode(mode),
    .i_strobe_edge_1(stb1), .i_strobe_edge_2(stb2), .i_window_end_1(wend1), .i_window_end_2(wend2),
    .i_cycle_length_1(len1), .i_cycle_length_2(len2), .i_test_cycle(test_cyc),
    .i_clr_fail(clr), .i_pin_in(pin),
    .o_sample(sample), .o_cycle_done(done), .o_cycle_fail(cfail), .o_fail(fail),
    .o_fail_count(fcnt)
  );

  function automatic void check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Reference model: records the pin seen at every tick and judges the whole cycle at its end.
  bit m_run, m_sample, m_done, m_cfail, m_fail;
  bit m_bexp, m_bmask, m_aexp, m_amask, m_wexp, m_wmask;
  int m_tick, m_len, m_stb, m_wend, m_mode, m_count;
  bit ph[S];
  bit hist[256];

  always @(posedge clk) begin
    bit seen, dn, cf;
    int last, hi;
    if (rst) begin
      m_run = 0; m_tick = 0; m_sample = 0; m_done = 0; m_cfail = 0; m_fail = 0; m_count = 0;
      m_bexp = 0; m_bmask = 0; m_aexp = 0; m_amask = 0; m_wexp = 0; m_wmask = 0;
      m_len = 0; m_stb = 0; m_wend = 0; m_mode = 0;
      for (int k = 0; k < S; k++) ph[k] = 0;
    end else begin
      seen = ph[S-1];
      for (int k = S-1; k > 0; k--) ph[k] = ph[k-1];
      ph[0] = pin;
      dn = 0; cf = 0;
      if (!en) begin
        m_run = 0; m_tick = 0;
      end else if (!m_run) begin
        m_run = 1;
      end else begin
        if (m_tick == 0) begin
          m_len  = test_cyc ? int'(len2)  : int'(len1);
          m_stb  = test_cyc ? int'(stb2)  : int'(stb1);
          m_wend = test_cyc ? int'(wend2) : int'(wend1);
          m_mode = int'(mode);
          m_wexp = m_aexp; m_wmask = m_amask;
        end
        last = (m_len <= 1) ? 0 : m_len - 1;
        hist[m_tick] = seen;
        if (m_tick == m_stb) m_sample = seen;
        if (m_tick == last) begin
          dn = 1;
          if (m_stb <= last && m_mode != 2) begin
            hi = m_stb;
            if (m_mode == 1) begin
              hi = (m_wend > last) ? last : m_wend;
              if (hi < m_stb) hi = m_stb;
            end
            for (int t = m_stb; t <= hi; t++)
              if (hist[t] != m_wexp && !m_wmask) cf = 1;
          end
          m_tick = 0;
        end else begin
          m_tick++;
        end
      end
      m_done = dn;
      if (dn) m_cfail = cf;
      m_fail = (m_fail && !clr) || (dn && cf);
`ifdef CMP_FAIL_COUNT_EN
      if (clr) m_count = (dn && cf) ? 1 : 0;
      else if (dn && cf && m_count < (1 << CW) - 1) m_count++;
`endif
      if (load) begin
        m_bexp = exp_v; m_bmask = mask_v;
      end else if (transfer) begin
        m_aexp = m_bexp; m_amask = m_bmask;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_done", int'(done), int'(m_done));
      check("m_cycle_fail", int'(cfail), int'(m_cfail));
      check("m_fail", int'(fail), int'(m_fail));
      check("m_sample", int'(sample), int'(m_sample));
      check("m_fail_count", int'(fcnt), m_count);
    end
  end

  typedef struct {
    logic [1:0] md; int len; int stb; int we;
    logic e; logic m; logic base; int gt;
    logic x_cf; logic x_smp;
  } vec_t;
  vec_t vt[13];

  int   dn_cnt;
  logic last_cf, last_smp;

  function automatic logic pin_at(input int ev, input int le, input logic base, input int gt);
    if (ev < 2) return base;
    return base ^ (((ev - 2) % le) == gt);
  endfunction

  task automatic set_cfg(input logic [1:0] md, input int L, input int sb, input int we);
    mode = md; len1 = L[7:0]; stb1 = sb[6:0]; wend1 = we[6:0]; test_cyc = 1'b0;
  endtask

  task automatic load_em(input logic e, input logic m);
    load = 1'b1; exp_v = e; mask_v = m;
    @(negedge clk);
    load = 1'b0; transfer = 1'b1;
    @(negedge clk);
    transfer = 1'b0;
  endtask

  // Starts from IDLE; pin is pre-skewed so tick t sees the intended value.
  task automatic run(input int L, input logic base, input int gt, input int ncyc);
    int le;
    le = (L <= 1) ? 1 : L;
    dn_cnt = 0;
    for (int e = 0; e <= 1 + ncyc * le; e++) begin
      en  = (e >= 1);
      pin = pin_at(e + 2, le, base, gt);
      @(negedge clk);
      if (done) begin
        dn_cnt++; last_cf = cfail; last_smp = sample;
      end
    end
    en = 1'b0;
    check("run_done_count", dn_cnt, ncyc);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dq[$];
    int nd;
    vt[0]  = '{2'd0, 10,  4,   0, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1};
    vt[1]  = '{2'd0, 10,  4,   0, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0};
    vt[2]  = '{2'd1, 10,  3,   7, 1'b1, 1'b0, 1'b1,  6, 1'b1, 1'b1};
    vt[3]  = '{2'd1, 10,  3,   7, 1'b1, 1'b0, 1'b1,  8, 1'b0, 1'b1};
    vt[4]  = '{2'd0, 10,  4,   0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1};
    vt[5]  = '{2'd2, 10,  4,   0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1};
    vt[6]  = '{2'd3, 10,  4,   0, 1'b1, 1'b0, 1'b1,  4, 1'b1, 1'b0};
    vt[7]  = '{2'd1,  8,  5,   2, 1'b1, 1'b0, 1'b1,  6, 1'b0, 1'b1};
    vt[8]  = '{2'd1,  8,  5, 100, 1'b1, 1'b0, 1'b1,  7, 1'b1, 1'b1};
    vt[9]  = '{2'd0, 12, 12,   0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1};
    vt[10] = '{2'd0,  1,  0,   0, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0};
    vt[11] = '{2'd2, 10,  4,   0, 1'b1, 1'b0, 1'b0,  4, 1'b0, 1'b1};
    vt[12] = '{2'd0,  0,  0,   0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b1};

    rst = 1'b1; en = 0; load = 0; transfer = 0; exp_v = 0; mask_v = 0; test_cyc = 0;
    clr = 0; pin = 0; mode = 0; stb1 = 0; stb2 = 0; wend1 = 0; wend2 = 0; len1 = 0; len2 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_sample", int'(sample), 0);
    check("rst_done", int'(done), 0);
    check("rst_cycle_fail", int'(cfail), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_fail_count", int'(fcnt), 0);
    chk_on = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_cfg(vt[i].md, vt[i].len, vt[i].stb, vt[i].we);
      load_em(vt[i].e, vt[i].m);
      run(vt[i].len, vt[i].base, vt[i].gt, 2);
      check($sformatf("vec%0d_cycle_fail", i), int'(last_cf), int'(vt[i].x_cf));
      check($sformatf("vec%0d_sample", i), int'(last_smp), int'(vt[i].x_smp));
    end

    // Sticky FAIL and its clear
    set_cfg(2'd0, 10, 4, 0);
    load_em(1'b1, 1'b0);
    pulse_clr();
    check("clr_fail", int'(fail), 0);
    run(10, 1'b0, -1, 1);
    check("sticky_cf_set", int'(last_cf), 1);
    check("sticky_set", int'(fail), 1);
    run(10, 1'b1, -1, 1);
    check("sticky_cf_pass", int'(last_cf), 0);
    check("sticky_hold", int'(fail), 1);
    pulse_clr();
    check("sticky_clr", int'(fail), 0);

    // LOAD and TRANSFER together: only the buffer moves
    load = 1'b1; transfer = 1'b1; exp_v = 1'b0;
    @(negedge clk);
    load = 1'b0; transfer = 1'b0;
    run(10, 1'b1, -1, 1);
    check("ld_xfer_active_kept", int'(last_cf), 0);
    transfer = 1'b1;
    @(negedge clk);
    transfer = 1'b0;
    run(10, 1'b1, -1, 1);
    check("xfer_new_exp", int'(last_cf), 1);

    // Timing-set switch mid-cycle takes effect at the next tick 0
    mode = 2'd0; len1 = 8'd8; len2 = 8'd12; stb1 = 7'd3; stb2 = 7'd3; wend1 = 0; wend2 = 0;
    load_em(1'b0, 1'b1);
    for (int e = 0; e <= 30; e++) begin
      en = (e >= 1);
      test_cyc = (e >= 4);
      @(negedge clk);
      if (done) dq.push_back(e);
    end
    en = 1'b0; test_cyc = 1'b0;
    check("tset_done_count", dq.size(), 2);
    if (dq.size() >= 2) begin
      check("tset_first_end", dq[0], 9);
      check("tset_second_end", dq[1], 21);
    end

    // Reset in mid-cycle
    set_cfg(2'd0, 10, 4, 0);
    load_em(1'b1, 1'b0);
    pin = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      en = (e >= 1);
      rst = (e == 16);
      @(negedge clk);
      if (e == 15) check("pre_rst_fail", int'(fail), 1);
    end
    rst = 1'b0;
    check("mid_rst_sample", int'(sample), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_cycle_fail", int'(cfail), 0);
    check("mid_rst_fail", int'(fail), 0);
    check("mid_rst_fail_count", int'(fcnt), 0);
    nd = 0;
    repeat (9) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("post_rst_no_done", nd, 0);
    en = 1'b0;

    // Saturating fail counter, and clear coinciding with a failing cycle
    set_cfg(2'd0, 1, 0, 0);
    load_em(1'b1, 1'b0);
    pin = 1'b0;
    for (int e = 0; e <= 25; e++) begin
      en = (e >= 1);
      @(negedge clk);
    end
    check("count_saturate", int'(fcnt), XSAT);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_vs_fail_count", int'(fcnt), XONE);
    check("clr_vs_fail_flag", int'(fail), 1);
    en = 1'b0;
    @(negedge clk);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      en       = ($urandom_range(0, 15) != 0);
      load     = ($urandom_range(0, 7) == 0);
      transfer = ($urandom_range(0, 5) == 0);
      exp_v    = 1'($urandom_range(0, 1));
      mask_v   = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 49) == 0);
      pin      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) test_cyc = ~test_cyc;
      if ($urandom_range(0, 29) == 0) begin
        mode  = 2'($urandom_range(0, 3));
        len1  = 8'($urandom_range(0, 14));
        len2  = 8'($urandom_range(0, 14));
        stb1  = 7'($urandom_range(0, 16));
        stb2  = 7'($urandom_range(0, 16));
        wend1 = 7'($urandom_range(0, 18));
        wend2 = 7'($urandom_range(0, 18));
      end
      @(negedge clk);
    end
    rst = 1'b0; en = 1'b0; load = 1'b0; transfer = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
